// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
//   fwd_sel_t    : E-stage operand mux select (regfile / Result in W / ALUOutM)
//   memw_state_t : data-memory wait FSM states
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT    = 2'b01,
        RELEASE = 2'b10
    } memw_state_t;

endpackage

// File: rtl/hazard_ctrl_mem_wait_fsm.sv
// Multi-cycle data-memory wait sequencer.
// Holds mem_busy high for exactly MEM_LAT consecutive cycles per access, then
// spends one RELEASE cycle with mem_busy low so the M-stage instruction leaves.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   mem_access_m  : M-stage instruction accesses dmem
//   mem_busy      : stall request for the whole pipeline
module mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_access_m,
    output logic mem_busy
);

    localparam int unsigned CW = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;

    memw_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mem_busy = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_access_m) begin
                    mem_busy = 1'b1;
                    cnt_d    = CW'(MEM_LAT - 1);
                    state_d  = (MEM_LAT > 1) ? WAIT : RELEASE;
                end
            end
            WAIT: begin
                mem_busy = 1'b1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = RELEASE;
                end
            end
            // The access that just completed is still in M here; do not retrigger.
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage (F/D/E/M/W) core.
// Operand forwarding, load-use stalls, PC-write flushes, dmem wait stalls and
// saturating stall/flush performance counters.
// Ports:
//   ra1d/ra2d, ra1e/ra2e      : D/E-stage source registers
//   wa3e/wa3m/wa3w, regwrite_*: destination register and write enable per stage
//   memtoreg_e                : E-stage instruction is a load
//   pcsrc_d/e/m/w             : instruction in that stage writes the PC
//   branch_taken_e            : E-stage branch resolved taken
//   mem_access_m              : M-stage instruction accesses dmem
//   forward_ae/be             : E-stage operand mux selects
//   stall_f/d/e/m, flush_d/e/w: pipeline register hold / bubble controls
//   stall_cnt, flush_cnt      : saturating counts of stall_f / flush_e cycles
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned RA_W    = 4,
    parameter int unsigned PC_REG  = 15,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RA_W-1:0]  ra1d,
    input  logic [RA_W-1:0]  ra2d,
    input  logic [RA_W-1:0]  ra1e,
    input  logic [RA_W-1:0]  ra2e,
    input  logic [RA_W-1:0]  wa3e,
    input  logic [RA_W-1:0]  wa3m,
    input  logic [RA_W-1:0]  wa3w,
    input  logic             regwrite_e,
    input  logic             regwrite_m,
    input  logic             regwrite_w,
    input  logic             memtoreg_e,
    input  logic             pcsrc_d,
    input  logic             pcsrc_e,
    input  logic             pcsrc_m,
    input  logic             pcsrc_w,
    input  logic             branch_taken_e,
    input  logic             mem_access_m,
    output logic [1:0]       forward_ae,
    output logic [1:0]       forward_be,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [RA_W-1:0] PC_IDX = RA_W'(PC_REG);

    logic       mem_busy;
    logic       ldrstall;
    logic       pc_pend;
    fwd_sel_t   fwd_a, fwd_b;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    generate
        if (MEM_LAT > 0) begin : g_memw
            mem_wait_fsm #(
                .MEM_LAT (MEM_LAT)
            ) u_mem_wait_fsm (
                .clk          (clk),
                .reset        (reset),
                .mem_access_m (mem_access_m),
                .mem_busy     (mem_busy)
            );
        end else begin : g_no_memw
            assign mem_busy = 1'b0;
        end
    endgenerate

    // Forwarding: M beats W; the PC is never forwarded.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (!reset) begin
            if (regwrite_m && (wa3m == ra1e) && (ra1e != PC_IDX))      fwd_a = FWD_M;
            else if (regwrite_w && (wa3w == ra1e) && (ra1e != PC_IDX)) fwd_a = FWD_W;
            if (regwrite_m && (wa3m == ra2e) && (ra2e != PC_IDX))      fwd_b = FWD_M;
            else if (regwrite_w && (wa3w == ra2e) && (ra2e != PC_IDX)) fwd_b = FWD_W;
        end
    end

    assign forward_ae = fwd_a;
    assign forward_be = fwd_b;

    assign ldrstall = memtoreg_e & regwrite_e & ((wa3e == ra1d) | (wa3e == ra2d));
    assign pc_pend  = pcsrc_d | pcsrc_e | pcsrc_m;

    // A dmem wait freezes every stage and overrides the hazard terms.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (reset) begin
            // all controls inactive
        end else if (mem_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else begin
            stall_f = ldrstall | pc_pend;
            stall_d = ldrstall;
            flush_d = pc_pend | pcsrc_w;
            flush_e = ldrstall | branch_taken_e;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_f && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_e && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a table of single-cycle hazard vectors plus
// hand-written multi-cycle sequences (branch shadow, dmem wait, reset in WAIT,
// counter saturation). Two instances: MEM_LAT=3/CNT_W=4 and MEM_LAT=1/CNT_W=16.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic       regwrite_e, regwrite_m, regwrite_w, memtoreg_e;
    logic       pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w, branch_taken_e, mem_access_m;

    logic [1:0]  fa3, fb3, fa1, fb1;
    logic        sf3, sd3, se3, sm3, fd3, fe3, fw3;
    logic        sf1, sd1, se1, sm1, fd1, fe1, fw1;
    logic [3:0]  scnt3, fcnt3;
    logic [15:0] scnt1, fcnt1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.RA_W(4), .PC_REG(15), .MEM_LAT(3), .CNT_W(4)) dut3 (
        .clk(clk), .reset(reset),
        .ra1d(ra1d), .ra2d(ra2d), .ra1e(ra1e), .ra2e(ra2e),
        .wa3e(wa3e), .wa3m(wa3m), .wa3w(wa3w),
        .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .memtoreg_e(memtoreg_e),
        .pcsrc_d(pcsrc_d), .pcsrc_e(pcsrc_e), .pcsrc_m(pcsrc_m), .pcsrc_w(pcsrc_w),
        .branch_taken_e(branch_taken_e), .mem_access_m(mem_access_m),
        .forward_ae(fa3), .forward_be(fb3),
        .stall_f(sf3), .stall_d(sd3), .stall_e(se3), .stall_m(sm3),
        .flush_d(fd3), .flush_e(fe3), .flush_w(fw3),
        .stall_cnt(scnt3), .flush_cnt(fcnt3)
    );

    hazard_ctrl #(.RA_W(4), .PC_REG(15), .MEM_LAT(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset),
        .ra1d(ra1d), .ra2d(ra2d), .ra1e(ra1e), .ra2e(ra2e),
        .wa3e(wa3e), .wa3m(wa3m), .wa3w(wa3w),
        .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .memtoreg_e(memtoreg_e),
        .pcsrc_d(pcsrc_d), .pcsrc_e(pcsrc_e), .pcsrc_m(pcsrc_m), .pcsrc_w(pcsrc_w),
        .branch_taken_e(branch_taken_e), .mem_access_m(mem_access_m),
        .forward_ae(fa1), .forward_be(fb1),
        .stall_f(sf1), .stall_d(sd1), .stall_e(se1), .stall_m(sm1),
        .flush_d(fd1), .flush_e(fe1), .flush_w(fw1),
        .stall_cnt(scnt1), .flush_cnt(fcnt1)
    );

    // A PC write in W never coincides with a dmem wait.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            assert (!(pcsrc_w && sm3)) else $error("pcsrc_w during dmem wait");
        end
    end

    typedef struct {
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic [2:0] rw;     // {e, m, w}
        logic       mte;
        logic [3:0] pc;     // {d, e, m, w}
        logic       br;
        logic [1:0] fa, fb;
        logic [3:0] ctl;    // {stall_f, stall_d, flush_d, flush_e}
    } vec_t;

    function automatic vec_t mk(input logic [3:0] a1d, a2d, a1e, a2e, we, wm, ww,
                                input logic [2:0] rw, input logic mte,
                                input logic [3:0] pc, input logic br,
                                input logic [1:0] fa, fb, input logic [3:0] ctl);
        vec_t v;
        v.ra1d = a1d; v.ra2d = a2d; v.ra1e = a1e; v.ra2e = a2e;
        v.wa3e = we;  v.wa3m = wm;  v.wa3w = ww;
        v.rw = rw; v.mte = mte; v.pc = pc; v.br = br;
        v.fa = fa; v.fb = fb; v.ctl = ctl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        {ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w} = '0;
        {regwrite_e, regwrite_m, regwrite_w, memtoreg_e} = '0;
        {pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w, branch_taken_e, mem_access_m} = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    vec_t vecs[16];

    initial begin
        int exp_s;
        int exp_fl;

        vecs[0]  = mk(0, 0,  3,  0, 0,  3,  3, 3'b011, 0, 4'b0000, 0, 2'b10, 2'b00, 4'b0000);
        vecs[1]  = mk(0, 0,  3,  0, 0,  3,  3, 3'b001, 0, 4'b0000, 0, 2'b01, 2'b00, 4'b0000);
        vecs[2]  = mk(0, 0, 15, 15, 0, 15, 15, 3'b011, 0, 4'b0000, 0, 2'b00, 2'b00, 4'b0000);
        vecs[3]  = mk(0, 0,  4,  4, 0,  9,  4, 3'b011, 0, 4'b0000, 0, 2'b01, 2'b01, 4'b0000);
        vecs[4]  = mk(0, 0,  0,  8, 0,  8,  0, 3'b010, 0, 4'b0000, 0, 2'b00, 2'b10, 4'b0000);
        vecs[5]  = mk(0, 2,  0,  0, 2,  0,  0, 3'b100, 1, 4'b0000, 0, 2'b00, 2'b00, 4'b1101);
        vecs[6]  = mk(2, 0,  0,  0, 2,  0,  0, 3'b000, 1, 4'b0000, 0, 2'b00, 2'b00, 4'b0000);
        vecs[7]  = mk(2, 0,  0,  0, 2,  0,  0, 3'b100, 0, 4'b0000, 0, 2'b00, 2'b00, 4'b0000);
        vecs[8]  = mk(2, 0,  0,  0, 2,  0,  0, 3'b100, 1, 4'b0000, 0, 2'b00, 2'b00, 4'b1101);
        vecs[9]  = mk(0, 0,  0,  0, 0,  0,  0, 3'b000, 0, 4'b1000, 0, 2'b00, 2'b00, 4'b1010);
        vecs[10] = mk(0, 0,  0,  0, 0,  0,  0, 3'b000, 0, 4'b0100, 0, 2'b00, 2'b00, 4'b1010);
        vecs[11] = mk(0, 0,  0,  0, 0,  0,  0, 3'b000, 0, 4'b0010, 0, 2'b00, 2'b00, 4'b1010);
        vecs[12] = mk(0, 0,  0,  0, 0,  0,  0, 3'b000, 0, 4'b0001, 0, 2'b00, 2'b00, 4'b0010);
        vecs[13] = mk(0, 0,  0,  0, 0,  0,  0, 3'b000, 0, 4'b0000, 1, 2'b00, 2'b00, 4'b0001);
        vecs[14] = mk(0, 2,  0,  0, 2,  0,  0, 3'b100, 1, 4'b1000, 0, 2'b00, 2'b00, 4'b1111);
        vecs[15] = mk(0, 0,  0,  0, 0,  0,  0, 3'b000, 0, 4'b0000, 0, 2'b00, 2'b00, 4'b0000);

        // Reset state: active hazards on the inputs must not reach the outputs.
        reset = 1'b1;
        clear_inputs();
        ra1e = 3; wa3m = 3; regwrite_m = 1; pcsrc_d = 1; branch_taken_e = 1;
        memtoreg_e = 1; regwrite_e = 1; wa3e = 2; ra2d = 2; mem_access_m = 1;
        tick();
        #1;
        chk("rst fwd_a", fa3, 2'b00);
        chk("rst ctl", {sf3, sd3, se3, sm3, fd3, fe3, fw3}, 7'b0);
        chk("rst cnt", {scnt3, fcnt3}, 8'h00);
        do_reset();

        // Single-cycle vector table (FSM idle, no dmem access).
        exp_s = 0;
        exp_fl = 0;
        for (int i = 0; i < 16; i++) begin
            ra1d = vecs[i].ra1d; ra2d = vecs[i].ra2d;
            ra1e = vecs[i].ra1e; ra2e = vecs[i].ra2e;
            wa3e = vecs[i].wa3e; wa3m = vecs[i].wa3m; wa3w = vecs[i].wa3w;
            {regwrite_e, regwrite_m, regwrite_w} = vecs[i].rw;
            memtoreg_e = vecs[i].mte;
            {pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w} = vecs[i].pc;
            branch_taken_e = vecs[i].br;
            #1;
            chk($sformatf("vec%0d fwd_a", i), fa3, vecs[i].fa);
            chk($sformatf("vec%0d fwd_b", i), fb3, vecs[i].fb);
            chk($sformatf("vec%0d ctl", i), {sf3, sd3, fd3, fe3}, vecs[i].ctl);
            chk($sformatf("vec%0d mem ctl", i), {se3, sm3, fw3}, 3'b000);
            if (vecs[i].ctl[3] && exp_s < 15) exp_s++;
            if (vecs[i].ctl[0] && exp_fl < 15) exp_fl++;
            tick();
        end
        clear_inputs();
        #1;
        chk("table stall_cnt", scnt3, exp_s);
        chk("table flush_cnt", fcnt3, exp_fl);

        // Load-use: one stall cycle.
        do_reset();
        memtoreg_e = 1; regwrite_e = 1; wa3e = 2; ra2d = 2;
        #1;
        chk("ldr ctl", {sf3, sd3, fe3}, 3'b111);
        tick();
        clear_inputs();
        #1;
        chk("ldr after stall_f", sf3, 1'b0);
        chk("ldr flush_cnt", fcnt3, 1);

        // Branch shadow: PC write walks D->E->M->W.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            {pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w} = 4'b1000 >> c;
            branch_taken_e = (c == 4);
            #1;
            chk($sformatf("br c%0d stall_f", c), sf3, c < 3);
            chk($sformatf("br c%0d flush_d", c), fd3, c < 4);
            chk($sformatf("br c%0d flush_e", c), fe3, c == 4);
            tick();
        end
        clear_inputs();
        #1;
        chk("br stall_cnt", scnt3, 3);
        chk("br flush_cnt", fcnt3, 1);

        // Dmem wait: access held 4 cycles. MEM_LAT=3 -> busy 1,1,1,0;
        // MEM_LAT=1 -> busy, release, busy, release.
        do_reset();
        mem_access_m = 1;
        for (int c = 0; c < 4; c++) begin
            branch_taken_e = (c == 0);
            #1;
            chk($sformatf("mem3 c%0d stall", c), {sf3, sd3, se3, sm3, fw3}, (c < 3) ? 5'b11111 : 5'b00000);
            chk($sformatf("mem3 c%0d flush_e", c), fe3, 1'b0);
            chk($sformatf("mem1 c%0d stall_m", c), sm1, (c % 2) == 0);
            tick();
        end
        clear_inputs();
        #1;
        chk("mem3 idle stall_m", sm3, 1'b0);
        chk("mem3 stall_cnt", scnt3, 3);
        chk("mem1 stall_cnt", scnt1, 2);

        // Reset during WAIT with cnt=1 abandons the access.
        do_reset();
        mem_access_m = 1;
        #1;
        chk("rw c0 stall_m", sm3, 1'b1);
        tick();
        chk("rw c1 stall_m", sm3, 1'b1);
        tick();
        reset = 1'b1;
        mem_access_m = 0;
        #1;
        chk("rw in-reset stall_m", sm3, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        chk("rw post stall_m", sm3, 1'b0);
        chk("rw post stall_cnt", scnt3, 0);
        tick();
        chk("rw post2 stall_m", sm3, 1'b0);

        // Saturation: stall_f held 20 cycles.
        do_reset();
        pcsrc_d = 1;
        repeat (14) tick();
        chk("sat 14 stall_cnt", scnt3, 14);
        repeat (6) tick();
        chk("sat 20 stall_cnt", scnt3, 15);
        chk("sat 20 wide stall_cnt", scnt1, 20);
        clear_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
